// File: rtl/period_meter_pkg.sv
// period_meter shared types and helpers.
// Imported by the measurement top level.
package period_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEEK_LOW,
    SEEK_RISE,
    MEASURE,
    TIMEOUT
  } state_t;

  function automatic logic [63:0] cnt_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with registered edge detection.
// Edges are suppressed until the pipe holds real samples.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_d;
  logic [SYNC_STAGES:0]   fill;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync <= '0;
      s_d  <= 1'b0;
      fill <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_in};
      s_d  <= sync[SYNC_STAGES-1];
      fill <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level = sync[SYNC_STAGES-1];

  // Reset zeros in the pipe would otherwise fake a rise on a high input.
  assign rise = fill[SYNC_STAGES] & level & ~s_d;
  assign fall = fill[SYNC_STAGES] & ~level & s_d;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow signal in CLOCK cycles.
// Reports each completed period with a one-cycle strobe.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic [15:0]      meas_count
);

  localparam logic [CNT_W-1:0] MAX  = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] LAST = MAX - CNT_W'(1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic             s;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hold;
  logic             at_last;
  logic             clr_cnt;
  logic             inc_cnt;
  logic             cap_fall;
  logic             report;
  logic             set_to;
  logic             clr_to;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .async_in(sig_in),
    .level   (s),
    .rise    (rise),
    .fall    (fall)
  );

  assign at_last = (cnt == LAST);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:      state_nx = SEEK_LOW;
        SEEK_LOW:  if (!s) state_nx = SEEK_RISE;
        SEEK_RISE: if (rise) state_nx = MEASURE;
        MEASURE:   if (!rise && at_last) state_nx = TIMEOUT;
        TIMEOUT:   if (rise) state_nx = MEASURE;
        default:   state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    clr_cnt  = 1'b0;
    inc_cnt  = 1'b0;
    cap_fall = 1'b0;
    report   = 1'b0;
    set_to   = 1'b0;
    clr_to   = 1'b0;
    if (enable) begin
      unique case (state)
        SEEK_RISE: clr_cnt = rise;
        MEASURE: begin
          clr_cnt  = rise;
          report   = rise;
          inc_cnt  = !rise;
          cap_fall = fall;
          set_to   = !rise && at_last;
        end
        TIMEOUT: begin
          clr_cnt = rise;
          clr_to  = rise;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)
      cnt <= '0;
    else if (!enable || state == IDLE || clr_cnt)
      cnt <= '0;
    else if (inc_cnt && cnt != MAX)
      cnt <= cnt + ONE;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      hold       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      meas_count <= '0;
    end else begin
      meas_valid <= report;
      if (cap_fall)
        hold <= cnt + ONE;
      if (report) begin
        period     <= cnt + ONE;
        high_time  <= hold;
        meas_count <= meas_count + 16'd1;
      end
      if (set_to)
        timeout <= 1'b1;
      else if (clr_to)
        timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter.
// Random square waves checked against a segment-based model.
module tb_period_meter;

  localparam int CW = 8;
  localparam int SS = 2;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          sig_in;
  logic          enable;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          timeout;
  logic [15:0]   meas_count;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            seg_h[64];
  int            seg_l[64];
  int            exp_p[$];
  int            exp_h[$];
  logic [15:0]   exp_cnt;
  logic [CW-1:0] hold_p;
  logic [CW-1:0] hold_h;

  always #5 CLOCK = ~CLOCK;

  period_meter #(
    .CNT_W      (CW),
    .SYNC_STAGES(SS)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .sig_in    (sig_in),
    .enable    (enable),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .timeout   (timeout),
    .meas_count(meas_count)
  );

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic do_reset(input logic sig0, input logic en0);
    RESET  = 1'b1;
    enable = en0;
    sig_in = sig0;
    cyc(3);
    exp_p.delete();
    exp_h.delete();
    exp_cnt = '0;
    hold_p  = '0;
    hold_h  = '0;
    RESET   = 1'b0;
  endtask

  task automatic set_segs(input int n, input int h, input int l);
    for (int i = 0; i < n; i++) begin
      seg_h[i] = h;
      seg_l[i] = l;
    end
  endtask

  // Each rise after the first closes the previous high+low segment.
  task automatic drive_wave(input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      if (i > 0) begin
        exp_p.push_back(seg_h[i-1] + seg_l[i-1]);
        exp_h.push_back(seg_h[i-1]);
      end
      cyc(seg_h[i]);
      sig_in = 1'b0;
      cyc(seg_l[i]);
    end
  endtask

  task automatic collect(input int n, input int budget,
                         input int spacing, input string name);
    int got;
    int waited;
    int last;
    logic [CW-1:0] p;
    logic [CW-1:0] h;
    got = 0;
    waited = 0;
    last = 0;
    while (got < n && waited < budget) begin
      @(negedge CLOCK);
      waited++;
      if (meas_valid) begin
        n_checks++;
        if (exp_p.size() == 0) begin
          n_fail++;
          $display("FAIL %s: unexpected report period=%0d high=%0d",
                   name, period, high_time);
        end else begin
          p = CW'(exp_p.pop_front());
          h = CW'(exp_h.pop_front());
          exp_cnt++;
          if (period !== p || high_time !== h || meas_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s: got period=%0d high=%0d count=%0d want %0d %0d %0d",
                     name, period, high_time, meas_count, p, h, exp_cnt);
          end
          hold_p = p;
          hold_h = h;
        end
        if (spacing > 0 && got > 0) begin
          n_checks++;
          if (waited - last != spacing) begin
            n_fail++;
            $display("FAIL %s_spacing: got %0d want %0d",
                     name, waited - last, spacing);
          end
        end
        last = waited;
        got++;
      end else begin
        n_checks++;
        if (period !== hold_p || high_time !== hold_h ||
            meas_count !== exp_cnt) begin
          n_fail++;
          $display("FAIL %s_hold: got %0d %0d %0d want %0d %0d %0d",
                   name, period, high_time, meas_count,
                   hold_p, hold_h, exp_cnt);
        end
      end
    end
    n_checks++;
    if (got != n) begin
      n_fail++;
      $display("FAIL %s_count: got %0d reports want %0d", name, got, n);
    end
  endtask

  task automatic watch_quiet(input int k, input string name);
    repeat (k) begin
      @(negedge CLOCK);
      n_checks++;
      if (meas_valid || period !== hold_p || high_time !== hold_h ||
          meas_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL %s: got v=%0d %0d %0d %0d want v=0 %0d %0d %0d",
                 name, meas_valid, period, high_time, meas_count,
                 hold_p, hold_h, exp_cnt);
      end
    end
  endtask

  task automatic test_reset;
    do_reset(1'b0, 1'b0);
    @(negedge CLOCK);
    n_checks++;
    if (period !== '0) begin
      n_fail++; $display("FAIL reset_period: got %0d want 0", period);
    end
    n_checks++;
    if (high_time !== '0) begin
      n_fail++; $display("FAIL reset_high: got %0d want 0", high_time);
    end
    n_checks++;
    if (meas_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %0d want 0", meas_valid);
    end
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_timeout: got %0d want 0", timeout);
    end
    n_checks++;
    if (meas_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", meas_count);
    end
  endtask

  task automatic test_div10;
    do_reset(1'b0, 1'b1);
    cyc(8);
    set_segs(4, 5, 5);
    fork
      drive_wave(4);
      collect(3, 60, 10, "div10");
    join
  endtask

  task automatic test_duty30;
    do_reset(1'b0, 1'b1);
    cyc(8);
    set_segs(5, 3, 7);
    fork
      drive_wave(5);
      collect(4, 70, 10, "duty30");
    join
  endtask

  task automatic test_random;
    int total;
    do_reset(1'b0, 1'b1);
    cyc(8);
    total = 0;
    for (int i = 0; i < 20; i++) begin
      seg_h[i] = int'($urandom_range(1, 12));
      seg_l[i] = int'($urandom_range(1, 12));
      total += seg_h[i] + seg_l[i];
    end
    fork
      drive_wave(20);
      collect(19, total + 20, 0, "random");
    join
  endtask

  task automatic test_high_at_reset;
    do_reset(1'b1, 1'b1);
    cyc(6);
    sig_in = 1'b0;
    cyc(4);
    set_segs(3, 4, 4);
    fork
      drive_wave(3);
      collect(2, 40, 8, "high_at_reset");
    join
  endtask

  task automatic test_timeout;
    int first;
    logic saw_valid;
    do_reset(1'b0, 1'b1);
    cyc(8);
    sig_in = 1'b1;
    first = -1;
    saw_valid = 1'b0;
    for (int j = 1; j <= 300; j++) begin
      @(negedge CLOCK);
      if (j == 4) sig_in = 1'b0;
      if (meas_valid) saw_valid = 1'b1;
      if (timeout && first < 0) first = j - 1;
    end
    n_checks++;
    if (first != SS + 1 + (2 ** CW - 1)) begin
      n_fail++;
      $display("FAIL timeout_edge: got %0d want %0d",
               first, SS + 1 + (2 ** CW - 1));
    end
    n_checks++;
    if (saw_valid || meas_count !== 16'd0) begin
      n_fail++;
      $display("FAIL timeout_noreport: got v=%0d count=%0d want 0 0",
               saw_valid, meas_count);
    end
    fork
      begin
        cyc(1);
        sig_in = 1'b1;
        cyc(2);
        sig_in = 1'b0;
        cyc(5);
        exp_p.push_back(7);
        exp_h.push_back(2);
        sig_in = 1'b1;
        cyc(3);
        sig_in = 1'b0;
      end
      collect(1, 30, 0, "timeout_recover");
    join
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: got %0d want 0", timeout);
    end
  endtask

  task automatic test_enable_reset;
    do_reset(1'b0, 1'b1);
    cyc(8);
    set_segs(10, 5, 5);
    fork
      drive_wave(10);
      begin
        collect(3, 50, 10, "en_run");
        enable = 1'b0;
        watch_quiet(50, "en_hold");
      end
    join
    n_checks++;
    if (period !== CW'(10) || high_time !== CW'(5) || meas_count !== 16'd3) begin
      n_fail++;
      $display("FAIL en_values: got %0d %0d %0d want 10 5 3",
               period, high_time, meas_count);
    end
    exp_p.delete();
    exp_h.delete();
    enable = 1'b1;
    cyc(8);
    set_segs(3, 6, 4);
    fork
      drive_wave(3);
      collect(2, 40, 10, "reenable");
    join
    @(posedge CLOCK);
    #2;
    RESET = 1'b1;
    #1;
    n_checks++;
    if (period !== '0 || high_time !== '0 || meas_valid !== 1'b0 ||
        timeout !== 1'b0 || meas_count !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %0d %0d %0d %0d %0d want all 0",
               period, high_time, meas_valid, timeout, meas_count);
    end
    cyc(2);
    RESET = 1'b0;
  endtask

  task automatic test_wrap;
    do_reset(1'b0, 1'b1);
    cyc(2);
    force dut.meas_count = 16'hFFFD;
    #1;
    release dut.meas_count;
    exp_cnt = 16'hFFFD;
    cyc(6);
    set_segs(4, 2, 2);
    fork
      drive_wave(4);
      collect(3, 30, 4, "wrap");
    join
    n_checks++;
    if (meas_count !== 16'd0) begin
      n_fail++; $display("FAIL wrap_final: got %0d want 0", meas_count);
    end
  endtask

  initial begin
    RESET  = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    test_reset();
    test_div10();
    test_duty30();
    test_random();
    test_high_at_reset();
    test_timeout();
    test_enable_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
